iob_post_ctrl: RTL and testbench
================================

Name: iob_post_ctrl

Overview:
- Sequences all CPU accesses that leave the accelerator for the motherboard I/O bus (IOB): posted RAM writes, plain I/O writes, I/O reads and SCSI cycles.
- Sits between the chip-select decode (IOCS, SCSICS, IOPWCS) and the IOB bus master.
- Absorbs writes in a small FIFO so the CPU is released early, and orders reads behind all pending writes.
- Single IOB channel is shared between the FIFO drain path and the direct (unbuffered) path.

Parameters:
- DEPTH, 2, number of posted-write FIFO entries (1..4).
- PTRW, 2, pointer width; must satisfy 2**PTRW >= DEPTH.

Ports:
- CLK  in  1  FSB clock.
- nRES  in  1  reset, asynchronous, active-low.
- BACT  in  1  CPU bus cycle active (AS asserted, synchronized).
- IOCS  in  1  I/O space select.
- SCSICS  in  1  SCSI select; never posted.
- IOPWCS  in  1  postable motherboard-RAM write select.
- nWE  in  1  CPU write strobe, low = write.
- A  in  23  CPU address A[23:1].
- D  in  16  CPU write data.
- nDS  in  2  {nUDS,nLDS}.
- FSBReady  out  1  one-cycle pulse terminating the CPU cycle.
- IOReq  out  1  IOB cycle request, held until IOAck.
- IOWr  out  1  IOB cycle is a write.
- IOA  out  23  IOB address.
- IOD  out  16  IOB write data.
- IODS  out  2  IOB active-low data strobes.
- IOAck  in  1  IOB cycle complete, 4-phase with IOReq.
- QEmpty  out  1  FIFO empty.

Behaviour:
- Reset (nRES low, asynchronous):
  - FSBReady=0, IOReq=0, IOWr=0, IOA=0, IOD=0, IODS=2'b11, QEmpty=1.
  - FIFO pointers and count cleared; FSM to IDLE. Applies mid-cycle; in-flight entries are discarded.
- Cycle start: BACT rising edge (registered BACT=0, current BACT=1) with (IOCS|IOPWCS|SCSICS). One decision per CPU cycle; a flag blocks re-decision until BACT falls.
- Classification at start:
  - POST = ~nWE & ~SCSICS & (IOPWCS|IOCS).
  - DIRECT = all other selected cycles (any read, any SCSI access).
- POST, FIFO not full:
  - Enqueue {A,D,nDS} on that edge.
  - FSBReady pulses the following cycle (1-cycle latency).
- POST, FIFO full:
  - Cycle held pending.
  - Enqueue on the first edge where count<DEPTH, or count==DEPTH with a dequeue the same edge (simultaneous push/pop permitted).
  - FSBReady the cycle after enqueue.
- DIRECT:
  - Held pending until FIFO empty and FSM IDLE, then issued on the direct path.
  - FSBReady pulses the cycle after IOAck is seen high; no early termination.
- Pending CPU cycle abandoned (BACT falls before service): drop the request; no FSBReady.
- FSM, one IOB channel:
  - IDLE -> DRAIN when FIFO non-empty. Head entry drives IOA/IOD/IODS, IOWr=1, IOReq=1.
  - IDLE -> DIRECT when FIFO empty and a DIRECT cycle is pending. Latches A/nDS, IOWr=~nWE, IOD=D for writes, IOReq=1.
  - DRAIN/DIRECT -> RELEASE on IOAck=1. IOReq=0; a DRAIN pops the FIFO on this edge.
  - RELEASE -> IDLE when IOAck=0.
  - Priority in IDLE: FIFO drain always beats DIRECT, so writes complete in program order ahead of any read.
- IOA/IOD/IODS/IOWr are stable for the whole time IOReq=1; they change only on the IDLE->DRAIN/DIRECT edge.
- IODS returns to 2'b11 in RELEASE and IDLE.
- QEmpty = (count==0), registered.
- Count arithmetic: pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows; a pop with count==0 is impossible by construction and is asserted against in simulation.
- IOAck high in IDLE (spurious) is ignored.

Test Plan:
- Reset mid-drain:
  - Stimulus: queue 2 writes, assert IOReq, pull nRES low.
  - Required: IOReq=0, QEmpty=1, IODS=11 immediately; after release, no IOB cycle without new stimulus.
- Single post:
  - Stimulus: write A=0x1F0000, D=0xBEEF, nDS=00 with IOPWCS.
  - Required: FSBReady 1 cycle after BACT rise. IOReq with IOA=0x1F0000, IOD=0xBEEF, IOWr=1; single IOB cycle; QEmpty=1 after RELEASE.
- FIFO full stall, DEPTH=2, IOAck held low:
  - Stimulus: three back-to-back posted writes.
  - Required: first two get FSBReady; the third gets none. Raise IOAck: the third enqueues on the pop edge, FSBReady next cycle; IOB order is 1,2,3.
- Read behind writes:
  - Stimulus: two posted writes, then IOCS read A=0x7FFFFE.
  - Required: read IOReq only after both drain cycles' RELEASE; IOWr=0; FSBReady 1 cycle after its IOAck.
- SCSI write not posted:
  - Stimulus: SCSICS write with empty FIFO.
  - Required: direct IOB cycle; FSBReady only after IOAck (latency >= IOB latency + 1).
- Abandon: DIRECT read pending behind a full FIFO, then BACT drops -> no FSBReady and no read IOB cycle; only queued writes drain.

Source files
------------

// File: rtl/iob_post_ctrl.sv
// IOB access sequencer: posts CPU writes through a small FIFO, issues reads and SCSI
// cycles directly once all posted writes have drained, over a single IOB channel.
module iob_post_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTRW  = 2,
    localparam int unsigned AW = 23,
    localparam int unsigned DW = 16,
    localparam int unsigned SW = 2
) (
    input  logic          CLK,
    input  logic          nRES,
    input  logic          BACT,
    input  logic          IOCS,
    input  logic          SCSICS,
    input  logic          IOPWCS,
    input  logic          nWE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic [SW-1:0] nDS,
    output logic          FSBReady,
    output logic          IOReq,
    output logic          IOWr,
    output logic [AW-1:0] IOA,
    output logic [DW-1:0] IOD,
    output logic [SW-1:0] IODS,
    input  logic          IOAck,
    output logic          QEmpty
);

    localparam int unsigned CW = PTRW + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] ds;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, DIRECT, RELEASE} state_t;

    state_t          state, state_d;
    logic            bact_q, decided, pend_post, pend_direct;
    logic [PTRW-1:0] wptr, rptr;
    logic [CW-1:0]   count, count_d;
    entry_t          fifo [DEPTH];
    entry_t          cpu_entry, head;

    logic            sel, start, is_post, full, push, pop, direct_go;
    logic            fsb_ready_d, io_req_d, io_wr_d;
    logic [AW-1:0]   io_a_d;
    logic [DW-1:0]   io_d_d;
    logic [SW-1:0]   io_ds_d;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // CPU cycle decode: one decision per BACT assertion; a full FIFO may accept on a pop edge
    always_comb begin
        sel       = IOCS | IOPWCS | SCSICS;
        start     = BACT & ~bact_q & sel & ~decided;
        is_post   = ~nWE & ~SCSICS & (IOPWCS | IOCS);
        full      = (count == CW'(DEPTH));
        pop       = (state == DRAIN) & IOAck;
        push      = BACT & ((start & is_post) | pend_post) & (~full | pop);
        direct_go = BACT & ((start & ~is_post) | pend_direct) & (state == IDLE) & (count == '0);
        cpu_entry = '{a: A, d: D, ds: nDS};
        head      = fifo[rptr];
        count_d   = count + CW'(push) - CW'(pop);
    end

    // IOB channel FSM; bus outputs only change when a cycle is launched or released
    always_comb begin
        state_d     = state;
        fsb_ready_d = push;
        io_req_d    = IOReq;
        io_wr_d     = IOWr;
        io_a_d      = IOA;
        io_d_d      = IOD;
        io_ds_d     = IODS;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_d  = DRAIN;
                    io_req_d = 1'b1;
                    io_wr_d  = 1'b1;
                    io_a_d   = head.a;
                    io_d_d   = head.d;
                    io_ds_d  = head.ds;
                end else if (direct_go) begin
                    state_d  = DIRECT;
                    io_req_d = 1'b1;
                    io_wr_d  = ~nWE;
                    io_a_d   = A;
                    io_ds_d  = nDS;
                    if (!nWE) io_d_d = D;
                end
            end
            DRAIN: begin
                if (IOAck) begin
                    state_d  = RELEASE;
                    io_req_d = 1'b0;
                    io_ds_d  = '1;
                end
            end
            DIRECT: begin
                if (IOAck) begin
                    state_d     = RELEASE;
                    io_req_d    = 1'b0;
                    io_ds_d     = '1;
                    fsb_ready_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!IOAck) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state       <= IDLE;
            bact_q      <= 1'b0;
            decided     <= 1'b0;
            pend_post   <= 1'b0;
            pend_direct <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            FSBReady    <= 1'b0;
            IOReq       <= 1'b0;
            IOWr        <= 1'b0;
            IOA         <= '0;
            IOD         <= '0;
            IODS        <= '1;
            QEmpty      <= 1'b1;
        end else begin
            state       <= state_d;
            bact_q      <= BACT;
            decided     <= BACT & (decided | start);
            pend_post   <= BACT & ~push & (pend_post | (start & is_post));
            pend_direct <= BACT & ~direct_go & (pend_direct | (start & ~is_post));
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            count       <= count_d;
            FSBReady    <= fsb_ready_d;
            IOReq       <= io_req_d;
            IOWr        <= io_wr_d;
            IOA         <= io_a_d;
            IOD         <= io_d_d;
            IODS        <= io_ds_d;
            QEmpty      <= (count_d == '0);
        end
    end

    // Posted-write storage needs no reset: entries are only read once counted valid
    always_ff @(posedge CLK) begin
        if (push) fifo[wptr] <= cpu_entry;
    end

    always @(posedge CLK) begin
        if (nRES) begin
            assert (!(pop && (count == '0)))
                else $error("iob_post_ctrl: pop from empty FIFO");
            assert (count <= CW'(DEPTH))
                else $error("iob_post_ctrl: FIFO count overflow");
        end
    end

endmodule

// File: tb/tb_iob_post_ctrl.sv
// Randomized scoreboard bench for iob_post_ctrl: expected IOB cycles follow CPU program
// order, a monitor checks each IOB cycle and FSBReady pulse as the DUT presents them.
module tb_iob_post_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PTRW  = 2;
    localparam int K_POST_PW = 0;
    localparam int K_POST_IO = 1;
    localparam int K_RD_IO   = 2;
    localparam int K_SCSI_WR = 3;
    localparam int K_SCSI_RD = 4;

    logic        CLK    = 1'b0;
    logic        nRES   = 1'b1;
    logic        BACT   = 1'b0;
    logic        IOCS   = 1'b0;
    logic        SCSICS = 1'b0;
    logic        IOPWCS = 1'b0;
    logic        nWE    = 1'b1;
    logic [22:0] A      = '0;
    logic [15:0] D      = '0;
    logic [1:0]  nDS    = 2'b11;
    logic        IOAck  = 1'b0;
    logic        FSBReady, IOReq, IOWr, QEmpty;
    logic [22:0] IOA;
    logic [15:0] IOD;
    logic [1:0]  IODS;

    iob_post_ctrl #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .CLK(CLK), .nRES(nRES), .BACT(BACT), .IOCS(IOCS), .SCSICS(SCSICS),
        .IOPWCS(IOPWCS), .nWE(nWE), .A(A), .D(D), .nDS(nDS),
        .FSBReady(FSBReady), .IOReq(IOReq), .IOWr(IOWr), .IOA(IOA), .IOD(IOD),
        .IODS(IODS), .IOAck(IOAck), .QEmpty(QEmpty)
    );

    typedef struct {
        bit          wr;
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ds;
        bit          posted;
    } iob_t;

    iob_t exp_q[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, ack_rise_cyc = -100, resp_wait = 0;
    int posts_issued = 0, posts_released = 0;
    int readies_exp = 0, readies_seen = 0;
    bit ack_en = 1'b1;
    bit mon_prev_req = 1'b0, mon_prev_rdy = 1'b0, mon_stable = 1'b1, mon_posted = 1'b0;
    logic [41:0] mon_cap;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever #5 CLK = ~CLK;
    initial forever begin @(posedge CLK); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // IOB slave: 4-phase handshake with a random 0..3 cycle response delay
    initial forever begin
        @(posedge CLK); #2;
        if (!nRES) begin
            IOAck = 1'b0;
            resp_wait = 0;
        end else if (IOAck) begin
            if (!IOReq) IOAck = 1'b0;
        end else if (IOReq && ack_en) begin
            if (resp_wait == 0) begin
                IOAck = 1'b1;
                ack_rise_cyc = cyc;
                resp_wait = $urandom_range(0, 3);
            end else begin
                resp_wait--;
            end
        end
    end

    // Monitor: compares each launched IOB cycle against the scoreboard head
    initial forever begin
        @(negedge CLK);
        if (!nRES) begin
            mon_prev_req = 1'b0;
            mon_prev_rdy = 1'b0;
        end else begin
            if (FSBReady) begin
                readies_seen++;
                chk("ready_one_cycle", mon_prev_rdy, 0);
            end
            if (IOReq && !mon_prev_req) begin
                chk("iob_cycle_expected", exp_q.size() != 0, 1);
                mon_posted = 1'b0;
                if (exp_q.size() != 0) begin
                    iob_t cur;
                    cur = exp_q.pop_front();
                    mon_posted = cur.posted;
                    chk("iob_wr", IOWr, cur.wr);
                    chk("iob_addr", IOA, cur.a);
                    chk("iob_ds", IODS, cur.ds);
                    if (cur.wr) chk("iob_data", IOD, cur.d);
                    if (!cur.posted) chk("direct_after_writes", posts_issued - posts_released, 0);
                end
                mon_cap = {IOWr, IOA, IOD, IODS};
                mon_stable = 1'b1;
            end else if (IOReq) begin
                if ({IOWr, IOA, IOD, IODS} != mon_cap) mon_stable = 1'b0;
            end else if (mon_prev_req) begin
                chk("iob_stable", mon_stable, 1);
                chk("iods_released", IODS, 2'b11);
                if (mon_posted) posts_released++;
            end
            mon_prev_req = IOReq;
            mon_prev_rdy = FSBReady;
        end
    end

    task automatic cpu_start(input int kind, input logic [22:0] a, input logic [15:0] d,
                             input logic [1:0] ds, input bit record,
                             output int start_cyc, output int occ);
        iob_t it;
        bit wr, posted;
        wr     = (kind == K_POST_PW) || (kind == K_POST_IO) || (kind == K_SCSI_WR);
        posted = (kind == K_POST_PW) || (kind == K_POST_IO);
        @(posedge CLK); #1;
        IOPWCS = (kind == K_POST_PW);
        IOCS   = (kind == K_POST_IO) || (kind == K_RD_IO);
        SCSICS = (kind == K_SCSI_WR) || (kind == K_SCSI_RD);
        nWE    = !wr;
        A      = a;
        D      = d;
        nDS    = ds;
        BACT   = 1'b1;
        start_cyc = cyc;
        occ = posts_issued - posts_released;
        if (record) begin
            it.wr = wr; it.a = a; it.d = d; it.ds = ds; it.posted = posted;
            exp_q.push_back(it);
            readies_exp++;
            if (posted) posts_issued++;
        end
    endtask

    task automatic wait_ready(input int max_cyc, output bit seen, output int rcyc);
        seen = 1'b0;
        rcyc = -1;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            @(negedge CLK);
            if (FSBReady) begin
                seen = 1'b1;
                rcyc = cyc;
            end
        end
    endtask

    task automatic cpu_end();
        @(posedge CLK); #1;
        BACT = 1'b0; IOCS = 1'b0; SCSICS = 1'b0; IOPWCS = 1'b0; nWE = 1'b1;
    endtask

    task automatic do_cycle(input int kind, input logic [22:0] a, input logic [15:0] d,
                            input logic [1:0] ds, input string tag);
        int sc, occ, rc;
        bit seen;
        cpu_start(kind, a, d, ds, 1'b1, sc, occ);
        wait_ready(200, seen, rc);
        chk({tag, "_ready_seen"}, seen, 1);
        if (seen) begin
            if (kind == K_POST_PW || kind == K_POST_IO) begin
                if (occ < int'(DEPTH)) chk({tag, "_post_latency"}, rc - sc, 1);
            end else begin
                chk({tag, "_ack_to_ready"}, rc - ack_rise_cyc, 1);
                chk({tag, "_not_early"}, (rc - sc) >= 2, 1);
            end
        end
        cpu_end();
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !IOReq && !IOAck && QEmpty) done = 1'b1;
        end
        @(negedge CLK);
        chk({tag, "_idle"}, done, 1);
    endtask

    initial begin
        int sc, occ, rc;
        bit seen;

        // Power-on reset
        #2 nRES = 1'b0;
        #1;
        chk("rst_fsbready", FSBReady, 0);
        chk("rst_ioreq", IOReq, 0);
        chk("rst_iowr", IOWr, 0);
        chk("rst_ioa", IOA, 0);
        chk("rst_iod", IOD, 0);
        chk("rst_iods", IODS, 2'b11);
        chk("rst_qempty", QEmpty, 1);
        repeat (3) @(posedge CLK);
        #1 nRES = 1'b1;

        // Reset while a drain is in flight
        ack_en = 1'b0;
        do_cycle(K_POST_PW, 23'h000100, 16'h1111, 2'b00, "rstmid_w1");
        do_cycle(K_POST_PW, 23'h000102, 16'h2222, 2'b00, "rstmid_w2");
        @(negedge CLK);
        chk("rstmid_req_before", IOReq, 1);
        @(posedge CLK); #3;
        nRES = 1'b0;
        #1;
        chk("rstmid_ioreq", IOReq, 0);
        chk("rstmid_qempty", QEmpty, 1);
        chk("rstmid_iods", IODS, 2'b11);
        exp_q.delete();
        posts_issued = posts_released;
        repeat (2) @(posedge CLK);
        #1 nRES = 1'b1;
        ack_en = 1'b1;
        repeat (10) @(negedge CLK);
        chk("rstmid_no_cycle", IOReq, 0);
        chk("rstmid_qempty_after", QEmpty, 1);

        // Single posted write
        do_cycle(K_POST_PW, 23'h1F0000, 16'hBEEF, 2'b00, "single");
        wait_idle("single");
        chk("single_qempty", QEmpty, 1);

        // FIFO full stall with IOAck held off
        ack_en = 1'b0;
        do_cycle(K_POST_PW, 23'h010000, 16'hA001, 2'b00, "stall_w1");
        do_cycle(K_POST_IO, 23'h010002, 16'hA002, 2'b01, "stall_w2");
        cpu_start(K_POST_PW, 23'h010004, 16'hA003, 2'b10, 1'b1, sc, occ);
        wait_ready(8, seen, rc);
        chk("stall_no_ready", seen, 0);
        ack_en = 1'b1;
        wait_ready(50, seen, rc);
        chk("stall_ready_seen", seen, 1);
        if (seen) chk("stall_ready_after_pop", rc - ack_rise_cyc, 1);
        cpu_end();
        wait_idle("stall");

        // Read ordered behind posted writes
        do_cycle(K_POST_IO, 23'h020000, 16'h5A5A, 2'b00, "rbw_w1");
        do_cycle(K_POST_PW, 23'h020002, 16'hA5A5, 2'b00, "rbw_w2");
        do_cycle(K_RD_IO, 23'h7FFFFE, 16'h0000, 2'b00, "rbw_read");
        wait_idle("rbw");

        // SCSI write is never posted
        do_cycle(K_SCSI_WR, 23'h0C0010, 16'hC0DE, 2'b00, "scsi");
        wait_idle("scsi");

        // Abandoned read behind a full FIFO
        ack_en = 1'b0;
        do_cycle(K_POST_PW, 23'h030000, 16'h0BAD, 2'b00, "abandon_w1");
        do_cycle(K_POST_PW, 23'h030002, 16'hF00D, 2'b00, "abandon_w2");
        cpu_start(K_RD_IO, 23'h030100, 16'h0000, 2'b00, 1'b0, sc, occ);
        wait_ready(6, seen, rc);
        chk("abandon_no_ready", seen, 0);
        cpu_end();
        ack_en = 1'b1;
        wait_idle("abandon");

        // Random mix of posted writes, reads and SCSI cycles
        for (int i = 0; i < 40; i++) begin
            do_cycle($urandom_range(0, 4), 23'($urandom()), 16'($urandom()),
                     2'($urandom_range(0, 2)), "rand");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge CLK);
        end
        wait_idle("rand");

        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_ready_count", readies_seen, readies_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
